// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential 8-bit signed radix-2 Booth multiplier (optional BOOTH_EARLY_DONE_EN early termination)
module booth_seq_mult (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] P,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state;
    logic [8:0]  M, AC, addend, sum;
    logic [7:0]  Q;
    logic        Q_1;
    logic [3:0]  cnt;
    logic [17:0] shifted;
`ifdef BOOTH_EARLY_DONE_EN
    logic [8:0]  mask;
    logic        tail_flat;
    logic [17:0] jumped;
`endif
    // Booth recode of {Q[0],Q_1}: add M, add inverted M plus one, or nothing; then one arithmetic shift
    always_comb begin
        addend  = (Q[0] ^ Q_1) ? (Q[0] ? (M ^ 9'h1FF) : M) : 9'h000;
        sum     = AC + addend + {8'd0, Q[0] & ~Q_1};
        shifted = $signed({sum, Q, Q_1}) >>> 1;
`ifdef BOOTH_EARLY_DONE_EN
        mask      = 9'h1FF >> cnt;
        tail_flat = ((({Q, Q_1}) ^ {9{Q_1}}) & mask) == 9'h000;
        jumped    = $signed({AC, Q, Q_1}) >>> (4'd8 - cnt);
`endif
    end
    // Control FSM with registered product, busy and done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            M     <= '0;
            AC    <= '0;
            Q     <= '0;
            Q_1   <= 1'b0;
            cnt   <= '0;
            P     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    M     <= {A[7], A};
                    AC    <= '0;
                    Q     <= B;
                    Q_1   <= 1'b0;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
`ifdef BOOTH_EARLY_DONE_EN
                    if (tail_flat) begin
                        {AC, Q, Q_1} <= jumped;
                        state        <= DONE;
                    end else begin
                        {AC, Q, Q_1} <= shifted;
                        cnt          <= cnt + 4'd1;
                        if (cnt == 4'd7) state <= DONE;
                    end
`else
                    {AC, Q, Q_1} <= shifted;
                    cnt          <= cnt + 4'd1;
                    if (cnt == 4'd7) state <= DONE;
`endif
                end
                DONE: if (!done) begin
                    P    <= {AC[7:0], Q};
                    done <= 1'b1;
                end else begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult: randomized self-checking bench for booth_seq_mult against an arithmetic product model
module tb_booth_seq_mult;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  A = '0;
    logic [7:0]  B = '0;
    logic [15:0] P;
    logic        busy, done;
    int          vectors = 0;
    int          errors = 0;
    logic [15:0] last_p = '0;

    booth_seq_mult dut (.clk(clk), .rst(rst), .start(start), .A(A), .B(B), .P(P), .busy(busy), .done(done));

    always #5 clk = ~clk;

    // Edge index after which done is expected; start is sampled on edge 0
    function automatic int exp_lat(input logic [7:0] b);
`ifdef BOOTH_EARLY_DONE_EN
        logic [8:0] x;
        x = {b, 1'b0};
        for (int k = 0; k < 8; k++)
            if ((x >> k) == 9'h000 || (x >> k) == (9'h1FF >> k)) return k + 2;
`endif
        return 9;
    endfunction

    task automatic do_mul(input logic [7:0] a, input logic [7:0] b);
        int n;
        int lat;
        logic [15:0] exp_p;
        exp_p = 16'($signed(a) * $signed(b));
        lat = exp_lat(b);
        @(negedge clk); A = a; B = b; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
            if (done !== 1'b1) begin
                vectors++;
                if (busy !== 1'b1 || P !== last_p) begin
                    errors++;
                    $display("FAIL run_hold a=%0d b=%0d edge=%0d busy=%b P=%h required busy=1 P=%h", $signed(a), $signed(b), n, busy, P, last_p);
                end
            end
        end
        vectors++;
        if (n !== lat) begin
            errors++;
            $display("FAIL latency a=%0d b=%0d got edge %0d required %0d", $signed(a), $signed(b), n, lat);
        end
        vectors++;
        if (P !== exp_p) begin
            errors++;
            $display("FAIL product a=%0d b=%0d got %h required %h", $signed(a), $signed(b), P, exp_p);
        end
        last_p = exp_p;
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse a=%0d b=%0d done=%b busy=%b required 0 0", $signed(a), $signed(b), done, busy);
        end
    endtask

    task automatic test_reset;
        #1;
        vectors++;
        if (P !== 16'h0000 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset P=%h done=%b busy=%b required 0000 0 0", P, done, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fixed_latency;
        do_mul(8'd7, 8'hFD);
    endtask

    task automatic test_abort;
        int dn;
        @(negedge clk); A = 8'd5; B = 8'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (P !== 16'h0000 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort P=%h done=%b busy=%b required 0000 0 0", P, done, busy);
        end
        @(negedge clk) rst = 1'b0;
        dn = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done === 1'b1) dn++;
        end
        vectors++;
        if (dn !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_nodone dones=%0d busy=%b required 0 0", dn, busy);
        end
        last_p = 16'h0000;
        do_mul(8'd5, 8'd3);
    endtask

    task automatic test_extremes;
        logic [7:0] ta [8];
        logic [7:0] tb [8];
        ta = '{8'h80, 8'h7F, 8'h80, 8'h00, 8'd10, 8'h33, 8'hFF, 8'h01};
        tb = '{8'h80, 8'h80, 8'h7F, 8'hFF, 8'h01, 8'h00, 8'hFF, 8'h40};
        for (int i = 0; i < 8; i++) do_mul(ta[i], tb[i]);
    endtask

    task automatic test_start_while_busy;
        int dn;
        @(negedge clk); A = 8'd9; B = 8'd9; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); A = 8'd2; B = 8'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        dn = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                dn++;
                vectors++;
                if (P !== 16'd81) begin
                    errors++;
                    $display("FAIL busy_ignore_product got %h required %h", P, 16'd81);
                end
            end
        end
        vectors++;
        if (dn !== 1) begin
            errors++;
            $display("FAIL busy_ignore_dones got %0d required 1", dn);
        end
        last_p = 16'd81;
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge clk); A = 8'd3; B = 8'd4; start = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (done !== 1'b1 && n < 20);
        vectors++;
        if (done !== 1'b1 || P !== 16'd12) begin
            errors++;
            $display("FAIL b2b_first done=%b P=%h required 1 %h", done, P, 16'd12);
        end
        A = 8'hFB; B = 8'd6;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (done !== 1'b1 && n < 20);
        start = 1'b0;
        vectors++;
        if (done !== 1'b1 || P !== 16'hFFE2) begin
            errors++;
            $display("FAIL b2b_second done=%b P=%h required 1 %h", done, P, 16'hFFE2);
        end
        repeat (2) @(posedge clk);
        #1 last_p = 16'hFFE2;
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) do_mul(8'($urandom), 8'($urandom));
    endtask

    initial begin
        test_reset;
        test_fixed_latency;
        test_abort;
        test_extremes;
        test_start_while_busy;
        test_back_to_back;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
